// File: rtl/line_serializer.sv
// rtl/line_serializer.sv - byte-to-serial line transmitter with optional even parity and FAS flagging
module line_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    input  logic        i_frame_data_fas,
    output logic        o_frame_data_ready,
    output logic        o_tx_serial,
    output logic        o_tx_busy,
    output logic        o_fas_sent,
    output logic [15:0] o_byte_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic        bit_done;

    assign bit_done = (baud_cnt == BAUD_LAST);

    // Ready is gated by reset directly so it can never be seen high while reset is held.
    assign o_frame_data_ready = (state == ST_IDLE) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            baud_cnt    <= 16'd0;
            bit_cnt     <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_busy   <= 1'b0;
            o_fas_sent  <= 1'b0;
            o_byte_cnt  <= 16'd0;
        end else begin
            o_fas_sent <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= 16'd0;
                    bit_cnt  <= 3'd0;
                    if (i_frame_data_valid) begin
                        shift_q     <= i_frame_data;
                        parity_q    <= ^i_frame_data;
                        o_tx_serial <= 1'b0;
                        o_tx_busy   <= 1'b1;
                        o_fas_sent  <= i_frame_data_fas;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        baud_cnt    <= 16'd0;
                        o_tx_serial <= shift_q[0];
                        state       <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= 16'd0;
                        // The shifter always presents the bit on the line at shift_q[0].
                        shift_q  <= {1'b0, shift_q[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            if (PARITY_EN) begin
                                o_tx_serial <= parity_q;
                                state       <= ST_PARITY;
                            end else begin
                                o_tx_serial <= 1'b1;
                                state       <= ST_STOP;
                            end
                        end else begin
                            bit_cnt     <= bit_cnt + 3'd1;
                            o_tx_serial <= shift_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        baud_cnt    <= 16'd0;
                        o_tx_serial <= 1'b1;
                        state       <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        baud_cnt   <= 16'd0;
                        o_tx_busy  <= 1'b0;
                        o_byte_cnt <= o_byte_cnt + 16'd1;
                        state      <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    baud_cnt    <= 16'd0;
                    bit_cnt     <= 3'd0;
                    o_tx_serial <= 1'b1;
                    o_tx_busy   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
